timer_ctrl: RTL

- Programmable interval timer controller that sequences a free-running up-counter datapath.
- Provides start/stop/pause control, a prescaled tick and a programmable terminal count.
- Supports one-shot and periodic modes.
- Sits between software-visible control registers and any block needing timed events (timeouts, periodic strobes); emits a single-cycle expire pulse.

---
 rtl/timer_ctrl_pkg.sv | 16 +
 rtl/timer_prescaler.sv | 30 +++
 rtl/timer_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared types and constants for the interval timer controller.
//   timer_state_t : controller FSM encoding (IDLE, RUN, PAUSE, DONE)
//   MODE_*        : values of the mode input / mode shadow register
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: tick divider for timer_ctrl. Counts 0..prescale and pulses
// tick on the terminal value, giving one tick every prescale+1 enabled cycles.
// Ports:
//   clk, rst   : clock, async active-low reset
//   clear      : synchronous clear to 0 (wins over en)
//   en         : advance enable; the count holds while low
//   prescale   : divider value P
//   tick       : combinational, high on the enabled cycle where count == P
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt;

  assign tick = en && (cnt == prescale);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en)    cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable interval timer controller.
// Config (mode/period/prescale) is captured into shadow registers on start only.
// Per-cycle priority: stop > start > pause > tick.
// Ports:
//   clk, rst             : clock, async active-low reset
//   start, stop, pause   : control (pause is a level)
//   mode                 : 0 one-shot, 1 periodic
//   period               : terminal count M
//   prescale             : tick divider P (tick every P+1 cycles)
//   busy, done           : state decodes (RUN/PAUSE, DONE)
//   count                : current main count
//   expire               : registered single-cycle pulse at terminal count
// Optional build macro TIMER_CTRL_IRQ_EN adds:
//   irq_clr (in), irq (out) : sticky expire flag, set wins over clear
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic                      mode,
  input  logic [COUNT_WIDTH-1:0]    period,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      busy,
  output logic                      done,
  output logic [COUNT_WIDTH-1:0]    count,
  output logic                      expire
`ifdef TIMER_CTRL_IRQ_EN
  ,
  input  logic                      irq_clr,
  output logic                      irq
`endif
);

  timer_state_t              state_q, state_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic [COUNT_WIDTH-1:0]    period_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic                      mode_q;
  logic                      expire_q, expire_d;
  logic                      load;
  logic                      psc_clear, psc_en, tick;

  // Active cycles: RUN, or PAUSE on the cycle pause drops. Treating the
  // release cycle as a live cycle makes a pause of N cycles delay the
  // timeline by exactly N, with no tick lost or duplicated.
  assign psc_clear = stop | start;
  assign psc_en    = !psc_clear && !pause && (state_q == RUN || state_q == PAUSE);

  timer_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_psc (
    .clk      (clk),
    .rst      (rst),
    .clear    (psc_clear),
    .en       (psc_en),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      expire_q   <= 1'b0;
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= MODE_ONESHOT;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      expire_q <= expire_d;
      if (load) begin
        period_q   <= period;
        prescale_q <= prescale;
        mode_q     <= mode;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    expire_d = 1'b0;
    load     = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      load    = 1'b1;
      state_d = RUN;
      count_d = '0;
    end else begin
      unique case (state_q)
        RUN, PAUSE: begin
          if (pause) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
            if (tick) begin
              if (count_q == period_q) begin
                count_d  = '0;
                expire_d = 1'b1;
                state_d  = (mode_q == MODE_PERIODIC) ? RUN : DONE;
              end else begin
                count_d = count_q + 1'b1;
              end
            end
          end
        end
        DONE:    count_d = '0;
        default: ;
      endcase
    end
  end

  assign busy   = (state_q == RUN) || (state_q == PAUSE);
  assign done   = (state_q == DONE);
  assign count  = count_q;
  assign expire = expire_q;

`ifdef TIMER_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          irq <= 1'b0;
    else if (expire_d) irq <= 1'b1;
    else if (irq_clr)  irq <= 1'b0;
  end
`endif

endmodule
